// File: rtl/gb_mem_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package     : gb_mem_pkg                                             |
// | Description : Shared types and address constants for the OAM DMA    |
// |               controller and its bus multiplexer.                    |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package gb_mem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DELAY = 2'd1,
    XFER  = 2'd2
  } dma_state_t;

  localparam logic [15:0] OAM_BASE  = 16'hFE00;
  localparam logic [15:0] DMA_REG   = 16'hFF46;
  localparam logic [15:0] HRAM_LO   = 16'hFF80;
  localparam logic [15:0] HRAM_HI   = 16'hFFFE;
  localparam logic [7:0]  ECHO_BASE = 8'hE0;

  // Source pages at or above E0 are echo RAM; fold them back onto C0-DF.
  function automatic logic [7:0] src_high(input logic [7:0] src);
    return (src >= ECHO_BASE) ? (src - 8'h20) : src;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dma_bus_mux.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : dma_bus_mux                                            |
// | Description : Combinational memory-port multiplexer between the OAM  |
// |               DMA engine and the CPU, plus CPU block/wait decode.    |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
// Ports:
//   i_active        transfer pending/running (CPU restricted to HRAM/FF46)
//   i_dma_own       DMA engine owns the memory port this cycle
//   i_dma_*         DMA-side address / write data / write strobe
//   i_rd_ff         a blocked read happened last cycle: return FF
//   i_cpu_*         CPU bus strobes, address and write data
//   i_mem_rdata     memory read data
//   o_mem_*         memory port address / write data / write strobe
//   o_cpu_din       data returned to the CPU
//   o_cpu_wait_n    low = CPU must hold its access
//   o_blocked_rd    CPU read that is being refused this cycle
//   o_dma_reg_wr    CPU write to the DMA start register
module dma_bus_mux (
  input  logic        i_active,
  input  logic        i_dma_own,
  input  logic [15:0] i_dma_addr,
  input  logic [7:0]  i_dma_wdata,
  input  logic        i_dma_write_n,
  input  logic        i_rd_ff,
  input  logic        i_cpu_read_n,
  input  logic        i_cpu_write_n,
  input  logic [15:0] i_cpu_address,
  input  logic [7:0]  i_cpu_dout,
  input  logic [7:0]  i_mem_rdata,
  output logic [15:0] o_mem_address,
  output logic [7:0]  o_mem_wdata,
  output logic        o_mem_write_n,
  output logic [7:0]  o_cpu_din,
  output logic        o_cpu_wait_n,
  output logic        o_blocked_rd,
  output logic        o_dma_reg_wr
);
  import gb_mem_pkg::*;

  logic w_rd;
  logic w_wr;
  logic w_hram;
  logic w_allowed;
  logic w_blocked;

  assign w_rd         = ~i_cpu_read_n;
  assign w_wr         = ~i_cpu_write_n;
  assign w_hram       = (i_cpu_address >= HRAM_LO) && (i_cpu_address <= HRAM_HI);
  assign o_dma_reg_wr = w_wr && (i_cpu_address == DMA_REG);
  assign w_allowed    = w_hram || o_dma_reg_wr;
  assign w_blocked    = i_active && !w_allowed;
  assign o_blocked_rd = w_blocked && w_rd;

  // Permitted accesses colliding with a DMA slot are stalled, not dropped.
  assign o_cpu_wait_n = !(i_active && i_dma_own && w_allowed && (w_rd || w_wr));

  assign o_mem_address = i_dma_own ? i_dma_addr    : i_cpu_address;
  assign o_mem_wdata   = i_dma_own ? i_dma_wdata   : i_cpu_dout;
  assign o_mem_write_n = i_dma_own ? i_dma_write_n : (i_cpu_write_n | w_blocked);

  assign o_cpu_din = i_rd_ff ? 8'hFF : i_mem_rdata;

endmodule
`default_nettype wire

// File: rtl/oam_dma_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : oam_dma_ctrl                                           |
// | Description : OAM DMA sequencer. A CPU write to FF46 copies XFER_LEN |
// |               bytes from page (FF46)<<8 to FE00.. while arbitrating  |
// |               the single memory port with the CPU.                   |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
// Ports:
//   clk, Reset                 clock, synchronous active-high reset
//   cpu_read_n/cpu_write_n     CPU strobes (active low)
//   cpu_address/cpu_dout       CPU address and write data
//   cpu_din/cpu_wait_n         CPU read data and hold request
//   mem_address/mem_wdata      memory port address and write data
//   mem_write_n/mem_rdata      memory write strobe, read data (1-cycle latency)
//   dma_active/dma_src         transfer busy flag, last FF46 value
module oam_dma_ctrl #(
  parameter int CYCLES_PER_BYTE = 4,
  parameter int START_DELAY     = 4,
  parameter int XFER_LEN        = 160
) (
  input  logic        clk,
  input  logic        Reset,
  input  logic        cpu_read_n,
  input  logic        cpu_write_n,
  input  logic [15:0] cpu_address,
  input  logic [7:0]  cpu_dout,
  output logic [7:0]  cpu_din,
  output logic        cpu_wait_n,
  output logic [15:0] mem_address,
  output logic [7:0]  mem_wdata,
  output logic        mem_write_n,
  input  logic [7:0]  mem_rdata,
  output logic        dma_active,
  output logic [7:0]  dma_src
);
  import gb_mem_pkg::*;

  localparam int c_PH_W = $clog2(CYCLES_PER_BYTE);
  localparam int c_DL_W = (START_DELAY > 1) ? $clog2(START_DELAY) : 1;

  dma_state_t        r_state;
  logic [c_PH_W-1:0] r_phase;
  logic [c_DL_W-1:0] r_delay;
  logic [7:0]        r_idx;
  logic [7:0]        r_buf;
  logic [7:0]        r_src;
  logic              r_active;
  logic              r_rd_ff;

  logic              w_trigger;
  logic              w_blocked_rd;
  logic              w_dma_own;
  logic              w_dma_write_n;
  logic [15:0]       w_dma_addr;

  // Phase 0 reads the source, phase 2 writes OAM; all other phases are CPU slots.
  assign w_dma_own     = (r_state == XFER) && ((r_phase == '0) || (r_phase == c_PH_W'(2)));
  assign w_dma_write_n = (r_phase != c_PH_W'(2));
  assign w_dma_addr    = (r_phase == '0) ? {src_high(r_src), r_idx}
                                         : (OAM_BASE | {8'h00, r_idx});

  assign dma_active = r_active;
  assign dma_src    = r_src;

  dma_bus_mux u_mux (
    .i_active      (r_active),
    .i_dma_own     (w_dma_own),
    .i_dma_addr    (w_dma_addr),
    .i_dma_wdata   (r_buf),
    .i_dma_write_n (w_dma_write_n),
    .i_rd_ff       (r_rd_ff),
    .i_cpu_read_n  (cpu_read_n),
    .i_cpu_write_n (cpu_write_n),
    .i_cpu_address (cpu_address),
    .i_cpu_dout    (cpu_dout),
    .i_mem_rdata   (mem_rdata),
    .o_mem_address (mem_address),
    .o_mem_wdata   (mem_wdata),
    .o_mem_write_n (mem_write_n),
    .o_cpu_din     (cpu_din),
    .o_cpu_wait_n  (cpu_wait_n),
    .o_blocked_rd  (w_blocked_rd),
    .o_dma_reg_wr  (w_trigger)
  );

  always_ff @(posedge clk) begin
    if (Reset) begin
      r_state  <= IDLE;
      r_phase  <= '0;
      r_delay  <= '0;
      r_idx    <= 8'h00;
      r_buf    <= 8'h00;
      r_src    <= 8'h00;
      r_active <= 1'b0;
      r_rd_ff  <= 1'b1;
    end else begin
      r_rd_ff  <= w_blocked_rd;
      // Stays high for one IDLE cycle after the last byte completes.
      r_active <= w_trigger || (r_state != IDLE);
      if (w_trigger) begin
        // Start/restart wins over everything else this cycle.
        r_src   <= cpu_dout;
        r_state <= DELAY;
        r_delay <= '0;
        r_idx   <= 8'h00;
        r_phase <= '0;
      end else begin
        case (r_state)
          DELAY: begin
            if (r_delay == c_DL_W'(START_DELAY - 1)) begin
              r_state <= XFER;
              r_phase <= '0;
            end else begin
              r_delay <= r_delay + c_DL_W'(1);
            end
          end
          XFER: begin
            if (r_phase == c_PH_W'(1)) begin
              r_buf <= mem_rdata;
            end
            if (r_phase == c_PH_W'(CYCLES_PER_BYTE - 1)) begin
              r_phase <= '0;
              if (r_idx == 8'(XFER_LEN - 1)) begin
                r_state <= IDLE;
                r_idx   <= 8'h00;
              end else begin
                r_idx <= r_idx + 8'h01;
              end
            end else begin
              r_phase <= r_phase + c_PH_W'(1);
            end
          end
          default: begin
            r_state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/oam_dma_ctrl.md
Name: oam_dma_ctrl

Overview:
- Sequences the OAM DMA transfer started by a CPU write to FF46: copies 160 bytes from (FF46 value)<<8 to FE00–FE9F.
- Sits between the CPU bus and the single-port main memory unit. Arbitrates that port between the DMA engine and the CPU.
- Blocks CPU access outside HRAM while a transfer runs.

Parameters:
- CYCLES_PER_BYTE, 4, clk cycles per transferred byte (minimum 3).
- START_DELAY, 4, clk cycles from the FF46 write to the first DMA read.
- XFER_LEN, 160, bytes per transfer.

Ports:
- clk  in  1  system clock
- Reset  in  1  synchronous, active-high reset
- cpu_read_n  in  1  CPU read strobe, active low
- cpu_write_n  in  1  CPU write strobe, active low
- cpu_address  in  16  CPU address
- cpu_dout  in  8  CPU write data
- cpu_din  out  8  read data returned to CPU
- cpu_wait_n  out  1  low = CPU must hold its current access
- mem_address  out  16  memory port address
- mem_wdata  out  8  memory port write data
- mem_write_n  out  1  memory port write strobe, active low
- mem_rdata  in  8  memory read data, valid 1 cycle after address
- dma_active  out  1  high while a transfer is pending or running
- dma_src  out  8  last value written to FF46

Behaviour:
- Reset:
  - state IDLE; dma_active=0; dma_src=00; cpu_wait_n=1; mem_write_n=1; cpu_din=FF; byte index=0; phase counter=0.
  - Reset mid-transfer aborts the transfer immediately. No further memory writes occur.
- Clock and reset: single clock `clk`; reset `Reset` is synchronous and active-high.
- IDLE (passthrough):
  - mem_address=cpu_address, mem_wdata=cpu_dout, mem_write_n=cpu_write_n.
  - cpu_din=mem_rdata; cpu_wait_n=1.
- Trigger:
  - A CPU write to FF46 (any state) latches dma_src=cpu_dout.
  - The write is also passed to memory whenever the CPU owns the port.
  - State goes to DELAY with delay count=0 and index=0.
  - dma_active rises on the next cycle.
- Source mapping: effective source high byte = dma_src when < E0, else dma_src−20h (echo RAM).
- DELAY: counts START_DELAY cycles, then enters XFER with phase=0.
- XFER, per byte i (0..XFER_LEN−1), phase p counts 0..CYCLES_PER_BYTE−1:
  - p=0: DMA drives mem_address={src_hi, i[7:0]}, mem_write_n=1.
  - p=1: latch mem_rdata into the byte buffer.
  - p=2: DMA drives mem_address=FE00+i, mem_wdata=buffer, mem_write_n=0.
  - p≥3: port free for the CPU.
  - After the last phase, i increments. When i=XFER_LEN−1 completes, go to IDLE. dma_active falls the following cycle.
- CPU arbitration while dma_active:
  - Allowed CPU region: FF80–FFFE and the FF46 write.
  - Allowed access on a DMA-owned phase (p=0 or 2): cpu_wait_n=0 that cycle; the CPU retries next cycle.
  - Allowed access on a free phase: passes through, as in IDLE.
  - Any other read returns FF on cpu_din, aligned one cycle after the request. No wait is inserted.
  - Any other write is dropped: mem_write_n stays high for the CPU.
- Restart: an FF46 write during DELAY or XFER restarts the transfer.
  - New source; i=0; DELAY re-entered.
  - A DMA write already in flight on the same cycle still completes.
- The FF46 write always takes priority over the abort/completion transition on the same cycle.
- dma_src reads back via normal memory; this block does not drive cpu_din for FF46.

Decomposition:
- Package `gb_mem_pkg`:
  - dma_state_t enum {IDLE, DELAY, XFER}.
  - Constants OAM_BASE=16'hFE00, DMA_REG=16'hFF46, HRAM_LO=16'hFF80, HRAM_HI=16'hFFFE, ECHO_BASE=8'hE0.
- Sub-module `dma_bus_mux`: combinational port mux and CPU block/wait decode, driven by owner/phase signals from the FSM.

Test Plan:
- Trigger transfer:
  - Stimulus: preload C000–C09F with i^5A; CPU writes FF46=C0.
  - Response: FE00–FE9F hold the pattern; dma_active high for exactly START_DELAY+160·CYCLES_PER_BYTE+1 cycles.
- Blocked CPU access:
  - Stimulus: during DMA, CPU reads 0150 and writes 55 to C100.
  - Response: read returns FF; C100 unchanged.
- HRAM access during DMA:
  - Stimulus: CPU writes/reads FF90 during DMA, including on a p=2 cycle.
  - Response: cpu_wait_n low for one cycle, then the access succeeds; the DMA byte is not corrupted.
- Restart:
  - Stimulus: FF46=C0, then FF46=D0 at byte 50.
  - Response: final OAM equals the D000–D09F contents.
- Echo source:
  - Stimulus: FF46=E1.
  - Response: the copy comes from C100–C19F.
- Reset mid-transfer:
  - Stimulus: Reset at byte 80.
  - Response: dma_active=0 next cycle; FE50–FE9F untouched; passthrough restored.
